// File: rtl/spike_rate_encoder.sv
// Rate-coded spike encoder: scans the pixel buffer once per timestep and emits AER events.
// Optional end-of-timestep marker events are built when SPK_EOT_MARKER_EN is defined.
module spike_rate_encoder #(
  parameter int NUM_PIXELS = 256,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 8,
  parameter int NUM_STEPS  = 16,
  parameter int STEP_W     = 4
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pix_ren,
  output logic [ADDR_W-1:0] pix_raddr,
  input  logic [PIX_W-1:0]  pix_rdata,
  output logic              aer_valid,
  input  logic              aer_ready,
  output logic [ADDR_W-1:0] aer_addr,
  output logic [STEP_W-1:0] aer_ts,
  output logic              aer_eot
);

  localparam int PROD_W = PIX_W + STEP_W + 1;
  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE, READ, EVAL, EMIT, DONE
`ifdef SPK_EOT_MARKER_EN
    , MARK
`endif
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [STEP_W-1:0] ts;
  } aer_evt_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pix;
  logic [STEP_W-1:0] t;
  aer_evt_t          evt;
  logic              busy_q, done_q;
  logic [PROD_W-1:0] prod_cur, prod_nxt;
  logic              spike, adv, start_ok, pix_last, step_last;

  // start coinciding with the done pulse must not relaunch
  assign start_ok  = (state == IDLE) && start && !done_q;
  assign pix_last  = (pix == PIX_LAST);
  assign step_last = (t == STEP_LAST);

  // spike when floor(t*p/2^PIX_W) steps up between t and t+1
  assign prod_cur = PROD_W'(t) * PROD_W'(pix_rdata);
  assign prod_nxt = prod_cur + PROD_W'(pix_rdata);
  assign spike    = (prod_nxt >> PIX_W) != (prod_cur >> PIX_W);

  always_comb begin
    state_n = state;
    adv     = 1'b0;
    case (state)
      IDLE: if (start_ok) state_n = READ;
      READ: state_n = EVAL;
      EVAL: if (spike) state_n = EMIT; else adv = 1'b1;
      EMIT: if (aer_ready) adv = 1'b1;
`ifdef SPK_EOT_MARKER_EN
      MARK: if (aer_ready) state_n = step_last ? DONE : READ;
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (adv) begin
      if (!pix_last) state_n = READ;
`ifdef SPK_EOT_MARKER_EN
      else state_n = MARK;
`else
      else state_n = step_last ? DONE : READ;
`endif
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state  <= IDLE;
      pix    <= '0;
      t      <= '0;
      evt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= (state == DONE);
      if (start_ok) begin
        pix    <= '0;
        t      <= '0;
        busy_q <= 1'b1;
      end else if (state == DONE) begin
        busy_q <= 1'b0;
      end
      if (state == EVAL && spike) evt <= '{addr: pix, ts: t};
      if (adv) begin
        if (!pix_last) begin
          pix <= pix + ADDR_W'(1);
        end else begin
          pix <= '0;
`ifdef SPK_EOT_MARKER_EN
          evt <= '{addr: '0, ts: t};
`else
          if (!step_last) t <= t + STEP_W'(1);
`endif
        end
      end
`ifdef SPK_EOT_MARKER_EN
      if (state == MARK && aer_ready && !step_last) t <= t + STEP_W'(1);
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_ren   = (state == READ);
  assign pix_raddr = pix;
  assign aer_addr  = evt.addr;
  assign aer_ts    = evt.ts;
`ifdef SPK_EOT_MARKER_EN
  assign aer_valid = (state == EMIT) || (state == MARK);
  assign aer_eot   = (state == MARK);
`else
  assign aer_valid = (state == EMIT);
  assign aer_eot   = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: pixel buffer model, AER collector, ready driver.
module tb_spike_rate_encoder;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pix_ren, aer_valid, aer_eot;
  logic       aer_ready;
  logic [7:0] pix_raddr, aer_addr;
  logic [7:0] pix_rdata = 8'h0;
  logic [3:0] aer_ts;

  logic [7:0]  mem [256];
  logic [11:0] evq [$];
  logic [3:0]  mkq [$];
  int          mk_bad = 0;
  int          stab_err = 0;
  int          rmode = 0;
  int          checks = 0;
  int          errors = 0;

  spike_rate_encoder dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .busy(busy), .done(done),
    .pix_ren(pix_ren), .pix_raddr(pix_raddr), .pix_rdata(pix_rdata),
    .aer_valid(aer_valid), .aer_ready(aer_ready), .aer_addr(aer_addr),
    .aer_ts(aer_ts), .aer_eot(aer_eot)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) if (pix_ren) pix_rdata <= mem[pix_raddr];

  // ready: 0 = always ready, 1 = random with long low stretches, 2 = stalled
  initial begin
    int lo;
    lo = 0;
    aer_ready = 1'b1;
    forever begin
      @(posedge ACLK); #1;
      if (rmode == 0) aer_ready = 1'b1;
      else if (rmode == 2) aer_ready = 1'b0;
      else if (lo > 0) begin aer_ready = 1'b0; lo--; end
      else if ($urandom_range(0, 31) == 0) begin lo = $urandom_range(20, 60); aer_ready = 1'b0; end
      else aer_ready = 1'($urandom_range(0, 1));
    end
  end

  // collect accepted events at negedge; handshake completes at the following posedge
  initial begin
    logic       stall;
    logic [11:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) stall = 1'b0;
      else begin
        if (stall && (!aer_valid || {aer_addr, aer_ts} !== held)) stab_err++;
        if (aer_valid && aer_ready) begin
          if (aer_eot) begin
            mkq.push_back(aer_ts);
            if (aer_addr !== 8'd0) mk_bad++;
          end else evq.push_back({aer_addr, aer_ts});
        end
        stall = aer_valid && !aer_ready;
        held  = {aer_addr, aer_ts};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  // one inference; cyc = cycles from the start cycle until done is seen
  task automatic run(input int budget, input bit mid_start, output int cyc);
    evq.delete();
    mkq.delete();
    @(posedge ACLK); #1 start = 1'b1;
    @(posedge ACLK); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc = 1;
    while (!done && cyc < budget) begin
      @(posedge ACLK); #1;
      cyc++;
      start = (mid_start && cyc == 100);
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    start = 1'b1;
    @(posedge ACLK); #1 start = 1'b0;
    chk("done_one_cycle", done, 0);
    repeat (3) @(posedge ACLK);
    #1 chk("no_restart_on_done_start", busy, 0);
  endtask

  initial begin
    int cyc, n;
    logic [11:0] e;
    fill(8'd0);
    #12;
    chk("rst_outputs", {busy, done, pix_ren, aer_valid, aer_eot}, 0);
    chk("rst_addrs", {pix_raddr, aer_addr, aer_ts}, 0);
    @(negedge ACLK) ARESETN = 1'b1;

    // mid-inference reset with a pending event
    fill(8'd255);
    rmode = 2;
    @(posedge ACLK); #1 start = 1'b1;
    @(posedge ACLK); #1 start = 1'b0;
    n = 0;
    while (!aer_valid && n < 2000) begin @(posedge ACLK); #1; n++; end
    chk("rst_pending_valid", aer_valid, 1);
    ARESETN = 1'b0;
    #1;
    chk("rst_mid_outputs", {busy, done, pix_ren, aer_valid, aer_eot}, 0);
    chk("rst_mid_addrs", {pix_raddr, aer_addr, aer_ts}, 0);
    @(negedge ACLK) ARESETN = 1'b1;
    rmode = 0;
    n = 0;
    repeat (40) begin @(posedge ACLK); #1; if (done || busy) n++; end
    chk("rst_no_done_busy", n, 0);
    chk("rst_no_events", evq.size(), 0);

    // single pixel 5 = 128 -> odd timesteps
    fill(8'd0);
    mem[5] = 8'd128;
    run(20000, 1'b0, cyc);
    chk("single_count", evq.size(), 8);
    for (int k = 0; k < 8 && k < evq.size(); k++)
      chk("single_evt", evq[k], {8'd5, 4'(2 * k + 1)});

    // boundary intensities
    fill(8'd0);
    mem[0]   = 8'd255;
    mem[255] = 8'd16;
    run(20000, 1'b0, cyc);
    chk("bound_count", evq.size(), 16);
    for (int k = 0; k < 15 && k < evq.size(); k++)
      chk("bound_p0", evq[k], {8'd0, 4'(k + 1)});
    if (evq.size() == 16) chk("bound_p255", evq[15], {8'd255, 4'd15});

    // backpressure, all pixels 255
    fill(8'd255);
    rmode = 1;
    stab_err = 0;
    run(60000, 1'b0, cyc);
    rmode = 0;
    chk("bp_count", evq.size(), 3840);
    chk("bp_stable", stab_err, 0);
    n = 0;
    for (int t = 1; t < 16; t++)
      for (int a = 0; a < 256; a++) begin
        e = (n < evq.size()) ? evq[n] : 12'hfff;
        if (e !== {8'(a), 4'(t)}) chk("bp_order", e, {8'(a), 4'(t)});
        n++;
      end
    chk("bp_order_all", n, 3840);

    // all-zero image, start while busy ignored
    fill(8'd0);
    run(20000, 1'b1, cyc);
    chk("zero_events", evq.size(), 0);
`ifdef SPK_EOT_MARKER_EN
    chk("zero_latency", cyc, 8210);
    chk("mark_count", mkq.size(), 16);
    chk("mark_addr", mk_bad, 0);
    for (int k = 0; k < 16 && k < mkq.size(); k++)
      chk("mark_ts", mkq[k], 4'(k));
`else
    chk("zero_latency", cyc, 8194);
    chk("no_markers", mkq.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
